// File: rtl/axi_regbank_pkg.sv
// axi_regbank_pkg: response codes and FSM state encodings shared by the
// AXI register bank and its byte-lane merge helper.
package axi_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'b00,
        W_COMMIT = 2'b01,
        W_RESP   = 2'b10
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_strb_merge.sv
// axi_strb_merge: byte-lane write mask. Each byte of the result comes from
// the new data when its strobe bit is set, otherwise from the old word.
module axi_strb_merge
    import axi_regbank_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W/8-1:0] strb_i,
    output logic [DATA_W-1:0]   merged_o
);

    // Pick every byte lane from new or old data according to its strobe
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (strb_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end else begin
                merged_o[8*i +: 8] = old_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/s_axi_regbank.sv
// s_axi_regbank: AXI register bank with independent AW/W capture, a
// three-state write FSM and a two-state read FSM with snapshot read data.
// Optional feature: define S_AXI_REGBANK_SLVERR_EN to answer out-of-range
// accesses with SLVERR instead of OKAY.
module s_axi_regbank
    import axi_regbank_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                areset,
    input  logic [ID_W-1:0]     awid_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i,
    input  logic [ID_W-1:0]     arid_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic                arvalid_i,
    output logic                arready_o,
    output logic [ID_W-1:0]     rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rvalid_o,
    input  logic                rready_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam logic [WORD_W-1:0] NUM_REGS_W = WORD_W'(NUM_REGS);

`ifdef S_AXI_REGBANK_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    // Word index (byte offset already stripped) inside the register array?
    function automatic logic word_in_range(input logic [WORD_W-1:0] word);
        return (word < NUM_REGS_W);
    endfunction

    // Write channel state
    wr_state_e           wr_state_q, wr_state_d;
    logic                aw_cap_q, aw_cap_d;
    logic                w_cap_q, w_cap_d;
    logic [WORD_W-1:0]   aw_word_q, aw_word_d;
    logic [ID_W-1:0]     awid_q, awid_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [ID_W-1:0]     bid_q, bid_d;
    logic [1:0]          bresp_q, bresp_d;

    // Register storage
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    // Read channel state
    rd_state_e           rd_state_q, rd_state_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [ID_W-1:0]     rid_q, rid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;

    // Combinational helpers
    logic                aw_hs_s, w_hs_s, b_hs_s, ar_hs_s;
    logic                wr_in_range_s, rd_in_range_s;
    logic [IDX_W-1:0]    wr_idx_s, rd_idx_s;
    logic [WORD_W-1:0]   rd_word_s;
    logic [DATA_W-1:0]   wr_old_s, wr_merged_s, rd_word_data_s;
    logic                unused_addr_s;

    assign aw_hs_s       = awvalid_i && awready_q;
    assign w_hs_s        = wvalid_i && wready_q;
    assign b_hs_s        = bvalid_q && bready_i;
    assign ar_hs_s       = arvalid_i && arready_q;
    assign rd_word_s     = araddr_i[ADDR_W-1:OFF_W];
    assign wr_in_range_s = word_in_range(aw_word_q);
    assign rd_in_range_s = word_in_range(rd_word_s);
    assign wr_idx_s      = aw_word_q[IDX_W-1:0];
    assign rd_idx_s      = rd_word_s[IDX_W-1:0];
    // Byte-offset bits never take part in decoding
    assign unused_addr_s = ^{awaddr_i[OFF_W-1:0], araddr_i[OFF_W-1:0]};

    // Current contents of the register targeted by the pending write
    always_comb begin
        if (wr_in_range_s) begin
            wr_old_s = regs_q[wr_idx_s];
        end else begin
            wr_old_s = {DATA_W{1'b0}};
        end
    end

    // Current contents of the register targeted by the incoming read
    always_comb begin
        if (rd_in_range_s) begin
            rd_word_data_s = regs_q[rd_idx_s];
        end else begin
            rd_word_data_s = {DATA_W{1'b0}};
        end
    end

    axi_strb_merge #(
        .DATA_W (DATA_W)
    ) u_strb_merge (
        .old_i    (wr_old_s),
        .new_i    (wdata_q),
        .strb_i   (wstrb_q),
        .merged_o (wr_merged_s)
    );

    // Write FSM: independent AW/W capture, commit, then hold B until accepted
    always_comb begin
        wr_state_d = wr_state_q;
        aw_cap_d   = aw_cap_q;
        w_cap_d    = w_cap_q;
        aw_word_d  = aw_word_q;
        awid_d     = awid_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;

        if (aw_hs_s) begin
            aw_cap_d  = 1'b1;
            aw_word_d = awaddr_i[ADDR_W-1:OFF_W];
            awid_d    = awid_i;
        end else begin
            aw_cap_d  = aw_cap_q;
        end

        if (w_hs_s) begin
            w_cap_d = 1'b1;
            wdata_d = wdata_i;
            wstrb_d = wstrb_i;
        end else begin
            w_cap_d = w_cap_q;
        end

        case (wr_state_q)
            W_IDLE: begin
                if (aw_cap_q && w_cap_q) begin
                    wr_state_d = W_COMMIT;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_COMMIT: begin
                bvalid_d   = 1'b1;
                bid_d      = awid_q;
                bresp_d    = wr_in_range_s ? RESP_OKAY : OOR_RESP;
                wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (b_hs_s) begin
                    bvalid_d   = 1'b0;
                    aw_cap_d   = 1'b0;
                    w_cap_d    = 1'b0;
                    wr_state_d = W_IDLE;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase

        // Ready stays low from capture until the B handshake releases it
        awready_d = ~aw_cap_d;
        wready_d  = ~w_cap_d;
    end

    // Register array update on commit of an in-range write
    always_comb begin
        regs_d = regs_q;
        if ((wr_state_q == W_COMMIT) && wr_in_range_s) begin
            regs_d[wr_idx_s] = wr_merged_s;
        end else begin
            regs_d = regs_q;
        end
    end

    // Read FSM: snapshot data on AR handshake, hold until R handshake
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rvalid_d   = 1'b1;
                    rid_d      = arid_i;
                    rdata_d    = rd_word_data_s;
                    rresp_d    = rd_in_range_s ? RESP_OKAY : OOR_RESP;
                    rd_state_d = R_DATA;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready_i) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase

        arready_d = (rd_state_d == R_IDLE);
    end

    // State and output registers; reset discards any captured transaction
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_state_q <= W_IDLE;
            aw_cap_q   <= 1'b0;
            w_cap_q    <= 1'b0;
            aw_word_q  <= {WORD_W{1'b0}};
            awid_q     <= {ID_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            wstrb_q    <= {STRB_W{1'b0}};
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= {ID_W{1'b0}};
            bresp_q    <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rid_q      <= {ID_W{1'b0}};
            rdata_q    <= {DATA_W{1'b0}};
            rresp_q    <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            aw_cap_q   <= aw_cap_d;
            w_cap_q    <= w_cap_d;
            aw_word_q  <= aw_word_d;
            awid_q     <= awid_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bid_o     = bid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

endmodule

// File: doc/s_axi_regbank.md
S_AXI_REGBANK -- requirements
Module: s_axi_regbank

Interface
REQ-001 DATA_W, 32, data width in bits; SHALL be 32 or 64.
REQ-002 NUM_REGS, 8, register count; SHALL be 2..256.
REQ-003 ID_W, 4, transaction ID width.
REQ-004 ADDR_W, 32, byte-address width.
REQ-005 clk  input  1  single system clock, rising edge.
REQ-006 areset  input  1  asynchronous active-low reset.
REQ-007 awid_i  input  ID_W  write address ID.
REQ-008 awaddr_i  input  ADDR_W  write byte address.
REQ-009 awvalid_i  input  1  write address valid.
REQ-010 awready_o  output  1  write address ready.
REQ-011 wdata_i  input  DATA_W  write data.
REQ-012 wstrb_i  input  DATA_W/8  byte strobes.
REQ-013 wvalid_i  input  1  write data valid.
REQ-014 wready_o  output  1  write data ready.
REQ-015 bid_o  output  ID_W  response ID, equals captured awid_i.
REQ-016 bresp_o  output  2  write response.
REQ-017 bvalid_o  output  1  response valid.
REQ-018 bready_i  input  1  response ready.
REQ-019 arid_i  input  ID_W  read address ID.
REQ-020 araddr_i  input  ADDR_W  read byte address.
REQ-021 arvalid_i  input  1  read address valid.
REQ-022 arready_o  output  1  read address ready.
REQ-023 rid_o  output  ID_W  read ID, equals captured arid_i.
REQ-024 rdata_o  output  DATA_W  read data.
REQ-025 rresp_o  output  2  read response.
REQ-026 rvalid_o  output  1  read valid.
REQ-027 rready_i  input  1  read ready.

Function
REQ-028 Decode SHALL use index = awaddr/araddr >> log2(DATA_W/8); low byte-offset bits ignored; index >= NUM_REGS is out-of-range.
REQ-029 AW and W SHALL be captured independently in any order or same cycle; awready_o drops the cycle after AW handshake, wready_o drops the cycle after W handshake, each held low until B handshake.
REQ-030 Write FSM states W_IDLE, W_COMMIT, W_RESP: W_IDLE->W_COMMIT when both captured; W_COMMIT writes enabled bytes (wstrb bit i -> byte i), asserts bvalid_o next cycle, ->W_RESP; W_RESP->W_IDLE on bvalid_o && bready_i, reasserting awready_o/wready_o the following cycle.
REQ-031 Write latency SHALL be 2 cycles from last of AW/W handshake to bvalid_o high; out-of-range writes SHALL modify no register.
REQ-032 bid_o/bresp_o SHALL stay stable while bvalid_o high and bready_i low.
REQ-033 Read FSM states R_IDLE, R_DATA: AR handshake (arready_o high in R_IDLE) loads rdata_o/rid_o/rresp_o, rvalid_o high next cycle; arready_o low in R_DATA; R_DATA->R_IDLE on rvalid_o && rready_i.
REQ-034 rdata_o SHALL hold the snapshot taken at AR handshake even if the register is written while rvalid_o waits; out-of-range reads return all zeros.
REQ-035 Same-cycle commit and AR handshake to one register SHALL return the pre-write value.

Reset
REQ-036 On areset low: all registers, bid_o, rid_o, rdata_o, bresp_o, rresp_o zero; bvalid_o, rvalid_o low; awready_o, wready_o, arready_o high one cycle after release; a mid-transaction reset SHALL discard captured AW/W/AR state.

Configuration
REQ-037 Macro S_AXI_REGBANK_SLVERR_EN: defined -> out-of-range access responds bresp_o/rresp_o = 2'b10 (SLVERR); undefined -> 2'b00 (OKAY); in-range always 2'b00.

Structure
REQ-038 Package axi_regbank_pkg SHALL hold the resp constants (RESP_OKAY, RESP_SLVERR) and the write/read FSM state enums; byte-lane write-mask logic SHALL be one sub-module axi_strb_merge.

Verification
REQ-039 AW addr 0x8 id 3, then W 0xDEADBEEF strb 0xF two cycles later -> reg2 = 0xDEADBEEF, bid_o=3, bresp_o=0, bvalid_o 2 cycles after W.
REQ-040 W before AW, strb 0x5 data 0xAABBCCDD onto reg1=0x11223344 -> reg1 = 0x11BB33DD.
REQ-041 Read addr 0x8 id 7 with rready_i low 5 cycles, write reg2 meanwhile -> rdata_o stays 0xDEADBEEF, rid_o=7, arready_o low until R handshake.
REQ-042 Write/read addr 0x40 (NUM_REGS=8) -> no reg change, rdata_o=0, resp 2'b10 with macro, 2'b00 without.
REQ-043 DATA_W=64, NUM_REGS=4: write addr 0x18 strb 0xF0 -> only upper 32 bits of reg3 change.
REQ-044 areset low during W_RESP with bready_i low -> bvalid_o low, all regs zero, all ready signals high after release.
